// File: rtl/ret_addr_stack.sv
// ret_addr_stack: LIFO of return addresses feeding the program counter's RET_ADDR input
module ret_addr_stack #(
    parameter int INSTR_ADDR_SIZE = 5,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CALL,
    input  logic                       RET,
    input  logic [INSTR_ADDR_SIZE-1:0] CALL_ADDR,
    input  logic                       CLR_ERR,
    output logic [INSTR_ADDR_SIZE-1:0] RET_ADDR,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic [CNT_W-1:0]           COUNT,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [INSTR_ADDR_SIZE-1:0] mem_q [DEPTH];
    logic [INSTR_ADDR_SIZE-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       ovf_q, ovf_d;
    logic                       unf_q, unf_d;
    logic                       empty, full;
    logic [IDX_W-1:0]           top_idx, wr_idx;
    logic [INSTR_ADDR_SIZE-1:0] push_val;

    assign empty    = cnt_q == '0;
    assign full     = cnt_q == CNT_W'(DEPTH);
    assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));
    assign wr_idx   = IDX_W'(cnt_q);
    assign push_val = CALL_ADDR + INSTR_ADDR_SIZE'(1);

    assign RET_ADDR  = empty ? '0 : mem_q[top_idx];
    assign EMPTY     = empty;
    assign FULL      = full;
    assign COUNT     = cnt_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

    // decode {CALL,RET} into the next stack contents, depth and sticky errors; error set beats clear
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        ovf_d = CLR_ERR ? 1'b0 : ovf_q;
        unf_d = CLR_ERR ? 1'b0 : unf_q;
        if (CALL && RET) begin
            if (empty) begin
                mem_d[0] = push_val;
                cnt_d    = CNT_W'(1);
                unf_d    = 1'b1;
            end else begin
                mem_d[top_idx] = push_val;
            end
        end else if (CALL) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                mem_d[wr_idx] = push_val;
                cnt_d         = cnt_q + CNT_W'(1);
            end
        end else if (RET) begin
            if (empty) unf_d = 1'b1;
            else cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // state registers; reset is asynchronous so outputs drop without a clock edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_q <= '{default: '0};
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack: scoreboard-driven checks of the return-address stack
module tb_ret_addr_stack;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       c;
        logic       r;
        logic       clr;
        logic [4:0] a;
    } op_t;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CALL = 1'b0;
    logic       RET = 1'b0;
    logic [4:0] CALL_ADDR = '0;
    logic       CLR_ERR = 1'b0;
    logic [4:0] RET_ADDR;
    logic       EMPTY, FULL, OVERFLOW, UNDERFLOW;
    logic [2:0] COUNT;
    logic [11:0] obs;

    logic [4:0] mdl [$];
    bit         m_o, m_u;
    exp_t       sb [$];
    int         n_chk = 0;
    int         n_pass = 0;

    ret_addr_stack #(.INSTR_ADDR_SIZE(5), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .CALL(CALL), .RET(RET), .CALL_ADDR(CALL_ADDR),
        .CLR_ERR(CLR_ERR), .RET_ADDR(RET_ADDR), .EMPTY(EMPTY), .FULL(FULL),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    assign obs = {RET_ADDR, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW};

    always #5 CLK = ~CLK;

    task automatic drive(input op_t o, input string tag);
        logic [4:0] p;
        int n;
        exp_t e;
        p = o.a + 5'd1;
        CALL = o.c;
        RET = o.r;
        CALL_ADDR = o.a;
        CLR_ERR = o.clr;
        if (o.clr) begin
            m_o = 0;
            m_u = 0;
        end
        if (o.c && o.r) begin
            if (mdl.size() == 0) begin
                mdl.push_back(p);
                m_u = 1;
            end else mdl[mdl.size()-1] = p;
        end else if (o.c) begin
            if (mdl.size() == DEPTH) m_o = 1;
            else mdl.push_back(p);
        end else if (o.r) begin
            if (mdl.size() == 0) m_u = 1;
            else void'(mdl.pop_back());
        end
        n = mdl.size();
        e.tag = tag;
        e.v = {(n != 0) ? mdl[n-1] : 5'd0, 3'(n), n == 0, n == DEPTH, m_o, m_u};
        sb.push_back(e);
        @(posedge CLK);
        #1;
        CALL = 0;
        RET = 0;
        CLR_ERR = 0;
    endtask

    task automatic test_reset();
        op_t ops [3];
        op_t hold;
        exp_t e;
        #12;
        n_chk++;
        if (obs !== 12'b00000_000_1000)
            $display("FAIL reset_initial: got %b want %b", obs, 12'b00000_000_1000);
        else n_pass++;
        @(negedge CLK);
        RST = 1;
        ops = '{'{1'b0, 1'b1, 1'b0, 5'd0}, '{1'b1, 1'b0, 1'b0, 5'd3}, '{1'b1, 1'b0, 1'b0, 5'd7}};
        foreach (ops[i]) begin
            drive(ops[i], "reset_pre");
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v)
                $display("FAIL %s[%0d]: got ra=%0d cnt=%0d efou=%b want ra=%0d cnt=%0d efou=%b",
                         e.tag, i, obs[11:7], obs[6:4], obs[3:0], e.v[11:7], e.v[6:4], e.v[3:0]);
            else n_pass++;
        end
        CALL = 1;
        CALL_ADDR = 5'd5;
        #2;
        RST = 0;
        #1;
        n_chk++;
        if (obs !== 12'b00000_000_1000)
            $display("FAIL reset_async: got %b want %b", obs, 12'b00000_000_1000);
        else n_pass++;
        mdl.delete();
        m_o = 0;
        m_u = 0;
        @(negedge CLK);
        CALL = 0;
        RST = 1;
        hold = '{1'b0, 1'b0, 1'b0, 5'd17};
        for (int i = 0; i < 10; i++) begin
            drive(hold, "reset_hold");
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v)
                $display("FAIL %s[%0d]: got ra=%0d cnt=%0d efou=%b want ra=%0d cnt=%0d efou=%b",
                         e.tag, i, obs[11:7], obs[6:4], obs[3:0], e.v[11:7], e.v[6:4], e.v[3:0]);
            else n_pass++;
        end
    endtask

    task automatic test_push_pop();
        op_t ops [3];
        op_t pop;
        logic [4:0] want [3];
        exp_t e;
        ops = '{'{1'b1, 1'b0, 1'b0, 5'd3}, '{1'b1, 1'b0, 1'b0, 5'd7}, '{1'b1, 1'b0, 1'b0, 5'd12}};
        foreach (ops[i]) begin
            drive(ops[i], "push");
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v)
                $display("FAIL %s[%0d]: got ra=%0d cnt=%0d efou=%b want ra=%0d cnt=%0d efou=%b",
                         e.tag, i, obs[11:7], obs[6:4], obs[3:0], e.v[11:7], e.v[6:4], e.v[3:0]);
            else n_pass++;
        end
        n_chk++;
        if (COUNT !== 3'd3 || RET_ADDR !== 5'd13)
            $display("FAIL push_top: got cnt=%0d ra=%0d want cnt=3 ra=13", COUNT, RET_ADDR);
        else n_pass++;
        want = '{5'd13, 5'd8, 5'd4};
        pop = '{1'b0, 1'b1, 1'b0, 5'd0};
        foreach (want[i]) begin
            n_chk++;
            if (RET_ADDR !== want[i])
                $display("FAIL pop_pre_edge[%0d]: got ra=%0d want %0d", i, RET_ADDR, want[i]);
            else n_pass++;
            drive(pop, "pop");
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v)
                $display("FAIL %s[%0d]: got ra=%0d cnt=%0d efou=%b want ra=%0d cnt=%0d efou=%b",
                         e.tag, i, obs[11:7], obs[6:4], obs[3:0], e.v[11:7], e.v[6:4], e.v[3:0]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        op_t ops [10];
        exp_t e;
        ops = '{'{1'b1, 1'b0, 1'b0, 5'd1}, '{1'b1, 1'b0, 1'b0, 5'd2}, '{1'b1, 1'b0, 1'b0, 5'd3},
                '{1'b1, 1'b0, 1'b0, 5'd4}, '{1'b1, 1'b0, 1'b0, 5'd5}, '{1'b0, 1'b0, 1'b1, 5'd0},
                '{1'b0, 1'b1, 1'b0, 5'd0}, '{1'b0, 1'b1, 1'b0, 5'd0}, '{1'b0, 1'b1, 1'b0, 5'd0},
                '{1'b0, 1'b1, 1'b0, 5'd0}};
        foreach (ops[i]) begin
            drive(ops[i], "overflow");
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v)
                $display("FAIL %s[%0d]: got ra=%0d cnt=%0d efou=%b want ra=%0d cnt=%0d efou=%b",
                         e.tag, i, obs[11:7], obs[6:4], obs[3:0], e.v[11:7], e.v[6:4], e.v[3:0]);
            else n_pass++;
            if (i == 4) begin
                n_chk++;
                if (obs !== 12'b00101_100_0110)
                    $display("FAIL overflow_full: got %b want %b", obs, 12'b00101_100_0110);
                else n_pass++;
            end
        end
    endtask

    task automatic test_underflow();
        op_t ops [4];
        exp_t e;
        ops = '{'{1'b0, 1'b1, 1'b0, 5'd0}, '{1'b1, 1'b1, 1'b0, 5'd9},
                '{1'b0, 1'b1, 1'b0, 5'd0}, '{1'b0, 1'b0, 1'b1, 5'd0}};
        foreach (ops[i]) begin
            drive(ops[i], "underflow");
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v)
                $display("FAIL %s[%0d]: got ra=%0d cnt=%0d efou=%b want ra=%0d cnt=%0d efou=%b",
                         e.tag, i, obs[11:7], obs[6:4], obs[3:0], e.v[11:7], e.v[6:4], e.v[3:0]);
            else n_pass++;
            if (i == 1) begin
                n_chk++;
                if (obs !== 12'b01010_001_0001)
                    $display("FAIL underflow_callret: got %b want %b", obs, 12'b01010_001_0001);
                else n_pass++;
            end
        end
    endtask

    task automatic test_replace_wrap();
        op_t ops [10];
        exp_t e;
        ops = '{'{1'b1, 1'b0, 1'b0, 5'd2}, '{1'b1, 1'b1, 1'b0, 5'd31}, '{1'b1, 1'b0, 1'b0, 5'd6},
                '{1'b1, 1'b0, 1'b0, 5'd10}, '{1'b1, 1'b0, 1'b0, 5'd14}, '{1'b1, 1'b1, 1'b0, 5'd20},
                '{1'b0, 1'b1, 1'b0, 5'd0}, '{1'b0, 1'b1, 1'b0, 5'd0}, '{1'b0, 1'b1, 1'b0, 5'd0},
                '{1'b0, 1'b1, 1'b0, 5'd0}};
        foreach (ops[i]) begin
            drive(ops[i], "replace");
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v)
                $display("FAIL %s[%0d]: got ra=%0d cnt=%0d efou=%b want ra=%0d cnt=%0d efou=%b",
                         e.tag, i, obs[11:7], obs[6:4], obs[3:0], e.v[11:7], e.v[6:4], e.v[3:0]);
            else n_pass++;
            if (i == 1) begin
                n_chk++;
                if (obs !== 12'b00000_001_0000)
                    $display("FAIL replace_wrap: got %b want %b", obs, 12'b00000_001_0000);
                else n_pass++;
            end
            if (i == 5) begin
                n_chk++;
                if (obs !== 12'b10101_100_0100)
                    $display("FAIL replace_full: got %b want %b", obs, 12'b10101_100_0100);
                else n_pass++;
            end
        end
    endtask

    task automatic test_clr_race();
        op_t ops [2];
        exp_t e;
        ops = '{'{1'b0, 1'b1, 1'b1, 5'd0}, '{1'b0, 1'b0, 1'b1, 5'd0}};
        foreach (ops[i]) begin
            drive(ops[i], "clr_race");
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v)
                $display("FAIL %s[%0d]: got ra=%0d cnt=%0d efou=%b want ra=%0d cnt=%0d efou=%b",
                         e.tag, i, obs[11:7], obs[6:4], obs[3:0], e.v[11:7], e.v[6:4], e.v[3:0]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        op_t o;
        exp_t e;
        for (int i = 0; i < 80; i++) begin
            o.c = 1'($urandom_range(0, 1));
            o.r = 1'($urandom_range(0, 2) == 0);
            o.clr = 1'($urandom_range(0, 7) == 0);
            o.a = 5'($urandom);
            drive(o, "random");
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v)
                $display("FAIL %s[%0d]: got ra=%0d cnt=%0d efou=%b want ra=%0d cnt=%0d efou=%b",
                         e.tag, i, obs[11:7], obs[6:4], obs[3:0], e.v[11:7], e.v[6:4], e.v[3:0]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace_wrap();
        test_clr_race();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
